// File: rtl/branch_pred_local_param_pkg.sv
// Shared types and counter constants for the local-history branch predictor.
// Counters start one step below the taken threshold (weakly not-taken).
package branch_pred_local_param_pkg;

   typedef enum logic [1:0] {
      OpHold,
      OpInc,
      OpDec
   } cntOp_t;

   localparam int unsigned StatW = 32;

   function automatic int unsigned cntInit(input int unsigned w);
      return (1 << (w - 1)) - 1;
   endfunction

   function automatic int unsigned cntMax(input int unsigned w);
      return (1 << w) - 1;
   endfunction

endpackage

// File: rtl/branch_pred_local_param_if.sv
// Datapath <-> predictor signal bundle: pipeline controls in, prediction and statistics out.
interface branch_pred_local_param_if;

   logic        pred_en;
   logic [31:0] pcF;
   logic        stallD;
   logic        flushD;
   logic        flushE;
   logic        flushM;
   logic        branchD;
   logic        branchM;
   logic        actual_takeM;
   logic        pred_takeD;
   logic        pred_wrongM;
   logic [31:0] br_cnt;
   logic [31:0] miss_cnt;

   modport master (
      output pred_en, pcF, stallD, flushD, flushE, flushM, branchD, branchM, actual_takeM,
      input  pred_takeD, pred_wrongM, br_cnt, miss_cnt
   );

   modport slave (
      input  pred_en, pcF, stallD, flushD, flushE, flushM, branchD, branchM, actual_takeM,
      output pred_takeD, pred_wrongM, br_cnt, miss_cnt
   );

endinterface

// File: rtl/branch_pred_local_param_sat_cnt.sv
// Single saturating up/down counter; synchronous active-low reset loads the weakly-not-taken value.
module branch_pred_local_param_sat_cnt
   import branch_pred_local_param_pkg::*;
#(
   parameter int unsigned CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  cntOp_t           op,
   output logic [CNT_W-1:0] cnt
);

   localparam logic [CNT_W-1:0] Init = CNT_W'(cntInit(CNT_W));
   localparam logic [CNT_W-1:0] Max  = CNT_W'(cntMax(CNT_W));

   logic [CNT_W-1:0] cntQ;
   logic [CNT_W-1:0] cntNext;

   always_comb begin
      cntNext = cntQ;
      unique case (op)
         OpInc:   if (cntQ != Max) cntNext = cntQ + CNT_W'(1);
         OpDec:   if (cntQ != '0)  cntNext = cntQ - CNT_W'(1);
         default: cntNext = cntQ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) cntQ <= Init;
      else      cntQ <= cntNext;
   end

   assign cnt = cntQ;

endmodule

// File: rtl/branch_pred_local_param.sv
// Two-level local-history branch predictor: per-PC history table indexing a shared counter table,
// looked up in F, predicted in D, trained non-speculatively in M.
module branch_pred_local_param
   import branch_pred_local_param_pkg::*;
#(
   parameter int unsigned BHT_IDX_W = 6,
   parameter int unsigned HIST_W    = 4,
   parameter int unsigned CNT_W     = 2,
   parameter int unsigned PC_LSB    = 2
) (
   input logic                      clk,
   input logic                      rst,
   branch_pred_local_param_if.slave bus
);

   localparam int unsigned BhtN = 1 << BHT_IDX_W;
   localparam int unsigned PhtN = 1 << HIST_W;

   typedef struct packed {
      logic                 valid;
      logic [BHT_IDX_W-1:0] idx;
      logic [HIST_W-1:0]    hist;
      logic                 predTake;
   } tag_t;

   logic [BhtN-1:0][HIST_W-1:0] bhtQ;
   logic [PhtN-1:0][CNT_W-1:0]  phtCnt;

   logic [BHT_IDX_W-1:0] idxF;
   tag_t                 tagF, tagDQ, tagDOut, tagEQ, tagMQ;
   logic                 predTakeD, resolveM, predWrongM;
   logic [StatW-1:0]     brCntQ, missCntQ;

   assign idxF = bus.pcF[PC_LSB +: BHT_IDX_W];

   always_comb begin
      tagF          = '0;
      tagF.valid    = 1'b1;
      tagF.idx      = idxF;
      tagF.hist     = bhtQ[idxF];
      tagF.predTake = 1'b0;
   end

   assign predTakeD  = tagDQ.valid & bus.branchD & bus.pred_en & phtCnt[tagDQ.hist][CNT_W-1];
   assign resolveM   = tagMQ.valid & bus.branchM;
   assign predWrongM = resolveM & (tagMQ.predTake != bus.actual_takeM);

   // The prediction is frozen into the tag so later pred_en changes cannot alter it.
   always_comb begin
      tagDOut          = tagDQ;
      tagDOut.predTake = predTakeD;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         tagDQ <= '0;
         tagEQ <= '0;
         tagMQ <= '0;
      end else begin
         if (bus.flushD)      tagDQ <= '0;
         else if (!bus.stallD) tagDQ <= tagF;
         tagEQ <= bus.flushE ? '0 : tagDOut;
         tagMQ <= bus.flushM ? '0 : tagEQ;
      end
   end

   // History update uses the tag's own history, not the (possibly newer) table entry.
   always_ff @(posedge clk) begin
      if (!rst) begin
         bhtQ <= '0;
      end else if (resolveM) begin
         bhtQ[tagMQ.idx] <= {tagMQ.hist[HIST_W-2:0], bus.actual_takeM};
      end
   end

   for (genvar g = 0; g < PhtN; g++) begin : gPht
      cntOp_t op;

      always_comb begin
         op = OpHold;
         if (resolveM && (tagMQ.hist == HIST_W'(g))) op = bus.actual_takeM ? OpInc : OpDec;
      end

      branch_pred_local_param_sat_cnt #(
         .CNT_W(CNT_W)
      ) uCnt (
         .clk(clk),
         .rst(rst),
         .op (op),
         .cnt(phtCnt[g])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         brCntQ   <= '0;
         missCntQ <= '0;
      end else begin
         if (resolveM && (brCntQ != '1))     brCntQ   <= brCntQ + StatW'(1);
         if (predWrongM && (missCntQ != '1)) missCntQ <= missCntQ + StatW'(1);
      end
   end

   assign bus.pred_takeD  = predTakeD;
   assign bus.pred_wrongM = predWrongM;
   assign bus.br_cnt      = brCntQ;
   assign bus.miss_cnt    = missCntQ;

endmodule

// File: tb/tb_branch_pred_local_param.sv
// Directed and random stimulus for the local-history predictor, checked each cycle against an
// instruction-level model built from integer tables.
module tb_branch_pred_local_param;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   branch_pred_local_param_if bus ();

   branch_pred_local_param #(
      .BHT_IDX_W(6),
      .HIST_W   (4),
      .CNT_W    (2),
      .PC_LSB   (2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      bit v;
      int idx;
      int hist;
      bit pt;
   } mtag_t;

   typedef struct {
      bit br;
      bit act;
   } slot_t;

   int          ph[16];
   int          bh[64];
   mtag_t       mD, mE, mM;
   longint      brN, missN;
   slot_t       sD, sE, sM;
   bit          stall, fD, fE, fM, en, rstn, chk;
   int          nTests, nFail;
   logic [31:0] pcs[4];

   // One clock cycle: drive, check combinational outputs, then advance the model at the edge.
   task automatic step(input logic [31:0] pc, input bit br, input bit act);
      bit    expPred, resolve, expWrong;
      mtag_t nD, nE, nM, zero;
      int    idxF;
      zero             = '{v: 1'b0, idx: 0, hist: 0, pt: 1'b0};
      rst              = rstn;
      bus.pcF          = pc;
      bus.stallD       = stall;
      bus.flushD       = fD;
      bus.flushE       = fE;
      bus.flushM       = fM;
      bus.pred_en      = en;
      bus.branchD      = sD.br;
      bus.branchM      = sM.br;
      bus.actual_takeM = sM.act;
      #2;
      expPred  = mD.v && sD.br && en && (ph[mD.hist] >= 2);
      resolve  = mM.v && sM.br;
      expWrong = resolve && (mM.pt != sM.act);
      if (chk) begin
         nTests++;
         assert (bus.pred_takeD === expPred) else begin
            nFail++;
            $error("FAIL pred_takeD observed=%0b expected=%0b at %0t", bus.pred_takeD, expPred,
                   $time);
         end
         nTests++;
         assert (bus.pred_wrongM === expWrong) else begin
            nFail++;
            $error("FAIL pred_wrongM observed=%0b expected=%0b at %0t", bus.pred_wrongM,
                   expWrong, $time);
         end
         nTests++;
         assert (bus.br_cnt === 32'(brN)) else begin
            nFail++;
            $error("FAIL br_cnt observed=%0d expected=%0d at %0t", bus.br_cnt, brN, $time);
         end
         nTests++;
         assert (bus.miss_cnt === 32'(missN)) else begin
            nFail++;
            $error("FAIL miss_cnt observed=%0d expected=%0d at %0t", bus.miss_cnt, missN, $time);
         end
      end
      @(posedge clk);
      if (!rstn) begin
         foreach (ph[i]) ph[i] = 1;
         foreach (bh[i]) bh[i] = 0;
         mD    = zero;
         mE    = zero;
         mM    = zero;
         brN   = 0;
         missN = 0;
      end else begin
         idxF = int'(pc[7:2]);
         nD   = fD ? zero : (stall ? mD : '{v: 1'b1, idx: idxF, hist: bh[idxF], pt: 1'b0});
         nE   = fE ? zero : '{v: mD.v, idx: mD.idx, hist: mD.hist, pt: expPred};
         nM   = fM ? zero : mE;
         if (resolve) begin
            if (sM.act) ph[mM.hist] = (ph[mM.hist] < 3) ? ph[mM.hist] + 1 : 3;
            else        ph[mM.hist] = (ph[mM.hist] > 0) ? ph[mM.hist] - 1 : 0;
            bh[mM.idx] = (mM.hist * 2 + int'(sM.act)) % 16;
            if (brN < 64'hFFFF_FFFF) brN++;
            if (expWrong && missN < 64'hFFFF_FFFF) missN++;
         end
         mD = nD;
         mE = nE;
         mM = nM;
      end
      sM = sE;
      sE = sD;
      if (!stall || fD) sD = '{br: br, act: act};
      #1;
   endtask

   task automatic bubbles(input int n);
      for (int i = 0; i < n; i++) step(32'h0000_1000, 1'b0, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      pcs    = '{32'h0000_0040, 32'h0000_0044, 32'h0000_0080, 32'h0000_0100};
      nTests = 0;
      nFail  = 0;
      stall  = 0;
      fD     = 0;
      fE     = 0;
      fM     = 0;
      en     = 1;
      sD     = '{br: 1'b0, act: 1'b0};
      sE     = sD;
      sM     = sD;
      chk    = 0;
      rstn   = 0;
      step(32'h0000_0040, 1'b1, 1'b1);
      chk  = 1;
      rstn = 1;

      // Reset state: branch in D but no valid tag yet.
      bubbles(3);

      // Always-taken loop, one branch in flight at a time.
      for (int i = 0; i < 6; i++) begin
         step(32'h0000_0040, 1'b1, 1'b1);
         bubbles(3);
      end

      // Alternating outcome at another PC.
      for (int i = 0; i < 12; i++) begin
         step(32'h0000_0080, 1'b1, bit'(i % 2));
         bubbles(3);
      end

      // Flush of the E->M, D->E and F->D tags in turn.
      step(32'h0000_0040, 1'b1, 1'b0);
      bubbles(1);
      fM = 1;
      bubbles(1);
      fM = 0;
      bubbles(3);
      step(32'h0000_0040, 1'b1, 1'b0);
      fE = 1;
      bubbles(1);
      fE = 0;
      bubbles(3);
      step(32'h0000_0040, 1'b1, 1'b0);
      fD = 1;
      bubbles(1);
      fD = 0;
      bubbles(3);

      // Stall holds the D tag; flush wins over stall.
      step(32'h0000_0040, 1'b1, 1'b1);
      stall = 1;
      for (int i = 0; i < 3; i++) step(32'h0000_0040, 1'b1, 1'b1);
      fD = 1;
      step(32'h0000_0040, 1'b1, 1'b1);
      stall = 0;
      fD    = 0;
      bubbles(4);

      // Static not-taken mode, back-to-back branches so F reads collide with M writes.
      en = 0;
      for (int i = 0; i < 12; i++) step(32'h0000_0040, 1'b1, 1'b1);
      en = 1;
      for (int i = 0; i < 8; i++) step(32'h0000_0040, 1'b1, 1'b1);
      bubbles(3);

      // Random traffic with occasional stalls, flushes, mode flips and resets.
      for (int i = 0; i < 500; i++) begin
         stall = ($urandom_range(9) == 0);
         fD    = ($urandom_range(19) == 0);
         fE    = ($urandom_range(19) == 0);
         fM    = ($urandom_range(19) == 0);
         en    = ($urandom_range(4) != 0);
         rstn  = ($urandom_range(99) != 0);
         step(pcs[$urandom_range(3)], bit'($urandom_range(1)), bit'($urandom_range(1)));
      end
      stall = 0;
      fD    = 0;
      fE    = 0;
      fM    = 0;
      rstn  = 1;
      bubbles(4);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
